// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO address/flag controller; optional sticky overflow/underflow flags under FIFO_ERR_FLAGS_EN
module fifo_ctrl #(
    parameter int FDEPTH   = 16,
    parameter int FCWIDTH  = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               writeN_in,
    input  logic               readN,
    output logic               writeN,
    output logic [FCWIDTH-1:0] wr_addr,
    output logic [FCWIDTH-1:0] rd_addr,
    output logic [FCWIDTH:0]   fcount,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic               overflow,
    output logic               underflow
`endif
);
    localparam logic [FCWIDTH:0] L_DEPTH = (FCWIDTH+1)'(FDEPTH);
    localparam logic [FCWIDTH:0] L_AF    = (FCWIDTH+1)'(AF_LEVEL);
    localparam logic [FCWIDTH:0] L_AE    = (FCWIDTH+1)'(AE_LEVEL);
    logic [FCWIDTH-1:0] r_wr_addr;
    logic [FCWIDTH-1:0] r_rd_addr;
    logic [FCWIDTH:0]   r_fcount;
    logic               w_rd_acc;
    logic               w_wr_acc;
    // a read frees a slot in the same edge, so a write at full is accepted alongside it
    always_comb begin
        w_rd_acc = !readN && !empty;
        w_wr_acc = !writeN_in && (!full || w_rd_acc);
    end
    assign writeN       = rst || !w_wr_acc;
    assign wr_addr      = r_wr_addr;
    assign rd_addr      = r_rd_addr;
    assign fcount       = r_fcount;
    assign full         = r_fcount == L_DEPTH;
    assign empty        = r_fcount == '0;
    assign almost_full  = r_fcount >= L_AF;
    assign almost_empty = r_fcount <= L_AE;
    // pointers wrap naturally; occupancy moves only when exactly one side is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_fcount  <= '0;
        end else begin
            if (w_wr_acc) r_wr_addr <= r_wr_addr + FCWIDTH'(1);
            if (w_rd_acc) r_rd_addr <= r_rd_addr + FCWIDTH'(1);
            if (w_wr_acc != w_rd_acc)
                r_fcount <= w_wr_acc ? r_fcount + (FCWIDTH+1)'(1) : r_fcount - (FCWIDTH+1)'(1);
        end
    end
`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    // sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (!writeN_in && full && !w_rd_acc) r_overflow <= 1'b1;
            if (!readN && empty) r_underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Address and flag controller that drives the FIFO memory block: generates its active-low write strobe, write address and read address.
- Converts upstream write requests and downstream read requests into pointer updates.
- Tracks occupancy and produces full/empty/almost flags.
- Memory read is combinational from rd_addr, so the FIFO is first-word-fall-through: the head word is valid on memory data_out whenever empty=0.

Parameters:
- FDEPTH, 16, number of words; must equal 2**FCWIDTH.
- FCWIDTH, 4, address width of wr_addr/rd_addr.
- AF_LEVEL, 14, almost_full asserts when fcount >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when fcount <= AE_LEVEL.

Ports:
- clk  input  1  rising-edge clock, shared with the memory block.
- rst  input  1  asynchronous active-high reset.
- writeN_in  input  1  upstream write request, active low.
- readN  input  1  downstream read/pop request, active low.
- writeN  output  1  memory write strobe, active low, combinational.
- wr_addr  output  FCWIDTH  memory write address (registered pointer).
- rd_addr  output  FCWIDTH  memory read address (registered pointer) = head of FIFO.
- fcount  output  FCWIDTH+1  current occupancy, 0..FDEPTH.
- full  output  1  fcount == FDEPTH.
- empty  output  1  fcount == 0.
- almost_full  output  1  fcount >= AF_LEVEL.
- almost_empty  output  1  fcount <= AE_LEVEL.

Behaviour:
- Reset (async, rst=1): wr_addr=0, rd_addr=0, fcount=0. Flags follow immediately: empty=1, almost_empty=1, full=0, almost_full=0. writeN=1 while rst=1.
- Read accept rd_acc = (readN==0) && !empty.
- Write accept wr_acc = (writeN_in==0) && (!full || rd_acc).
- writeN = ~wr_acc, combinational. Memory captures data at wr_addr on the same clk edge.
- On each rising edge with rst=0:
  - wr_addr increments by 1 if wr_acc.
  - rd_addr increments by 1 if rd_acc.
  - fcount: +1 if wr_acc only, -1 if rd_acc only, unchanged if both or neither.
- Pointers wrap modulo FDEPTH (natural FCWIDTH-bit rollover, 15 -> 0 at default).
- Flags are combinational decodes of registered fcount, so they update in the cycle after the accepting edge. No extra latency.
- Data latency: a word written at edge N is visible on memory data_out from edge N (when it was the only word) and is popped by a read accepted at any later edge.
- Write at full without a read: dropped; writeN stays 1; pointers and fcount unchanged.
- Write and read together at full: both accepted; fcount stays FDEPTH.
- Read at empty: ignored; rd_addr and fcount unchanged, even with a simultaneous write. The written word becomes the head next cycle.
- Write and read together at fcount=1: both accepted; fcount stays 1; head advances to the new word.
- Reset asserted mid-operation: all state clears asynchronously; memory contents are not cleared but are unreachable.
- X on writeN_in/readN while rst=0 is illegal (verification assertion).

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, adds ports overflow (output, 1) and underflow (output, 1), both sticky.
  - overflow sets at the edge where writeN_in==0 && full && !rd_acc.
  - underflow sets at the edge where readN==0 && empty.
  - Both clear only on rst; reset value 0.
  - Core behaviour is identical with or without the macro.
- When undefined, these ports and their registers do not exist.

Test Plan:
- Reset then idle -> fcount=0, empty=1, almost_empty=1, full=0, writeN=1, wr_addr=rd_addr=0.
- 16 consecutive writes (writeN_in=0) -> fcount=16, full=1, wr_addr=0 (wrapped); almost_full asserts after the 14th edge; almost_empty deasserts after the 3rd.
- At full, one more write with readN=1 -> writeN=1, fcount=16, wr_addr unchanged; overflow=1 if FIFO_ERR_FLAGS_EN.
- At full, simultaneous write+read for 20 cycles -> fcount stays 16, both pointers advance 20 (mod 16 = 4), data read out in write order.
- From empty, readN=0 with writeN_in=0 -> rd_addr stays 0, fcount=1, underflow=1 if FIFO_ERR_FLAGS_EN. Next cycle the read pops: rd_addr=1, fcount=1 if the write continues.
- Write 5 words, assert rst asynchronously between edges -> outputs return to reset values immediately. Subsequent writes start at wr_addr=0.
